load_store_unit: RTL and testbench

Memory-stage access unit between the EX/MEM pipeline register and a multi-cycle data memory. It decodes `func3` into byte enables, write-data lanes and load extraction. It drives a request/acknowledge handshake to the memory and stalls the whole pipeline while an access is outstanding. It also flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: decodes func3 into lanes, runs a req/ack
// handshake to a multi-cycle data memory, and stalls the pipeline meanwhile.
module load_store_unit #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [DM_ADDRESS-1:0] ex_addr,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [2:0]            ex_func3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  access_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  // state  | meaning
  // IDLE   | examine ex_* for a new access
  // WAIT   | request outstanding, waiting for mem_ack or timeout
  // DONE   | pipeline released; one bubble before the next access
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DM_ADDRESS-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  fault_q, fault_d;
  logic [2:0]            func3_q, func3_d;
  logic [1:0]            off_q, off_d;

  logic [1:0]        off;
  logic              is_rd, is_wr, func3_ok, aligned, legal, fault_in;
  logic [3:0]        be_dec;
  logic [DATA_W-1:0] wdata_dec, shifted, load_ext;

  assign off   = ex_addr[1:0];
  assign is_rd = ex_mem_read & ~ex_mem_write;
  assign is_wr = ex_mem_write & ~ex_mem_read;

  always_comb begin
    func3_ok = 1'b0;
    if (is_rd)
      func3_ok = (ex_func3 == 3'b000) || (ex_func3 == 3'b001) || (ex_func3 == 3'b010) ||
                 (ex_func3 == 3'b100) || (ex_func3 == 3'b101);
    else if (is_wr)
      func3_ok = (ex_func3 == 3'b000) || (ex_func3 == 3'b001) || (ex_func3 == 3'b010);
  end

  always_comb begin
    aligned   = 1'b1;
    be_dec    = 4'b1111;
    wdata_dec = ex_wdata;
    case (ex_func3[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << off;
        wdata_dec = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        aligned   = (off[0] == 1'b0);
        be_dec    = 4'b0011 << off;
        wdata_dec = {2{ex_wdata[15:0]}};
      end
      default: aligned = (off == 2'b00);
    endcase
  end

  // A both-high request falls out of legal because neither is_rd nor is_wr is set.
  assign legal    = (is_rd | is_wr) & func3_ok & aligned;
  assign fault_in = (ex_mem_read | ex_mem_write) & ~legal;

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = '0;
    case (func3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = shifted;
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  assign stall = (state_q == S_WAIT) || ((state_q == S_IDLE) && legal);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    fault_d     = 1'b0;
    func3_d     = func3_q;
    off_d       = off_q;
    case (state_q)
      S_IDLE: begin
        if (legal) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_wr;
          mem_addr_d  = ex_addr[DM_ADDRESS-1:2];
          mem_be_d    = be_dec;
          mem_wdata_d = wdata_dec;
          func3_d     = ex_func3;
          off_d       = off;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end else if (fault_in) begin
          fault_d   = 1'b1;
          rd_data_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) rd_data_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          rd_data_d = '0;
          fault_d   = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      fault_q     <= 1'b0;
      func3_q     <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      fault_q     <= fault_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign access_fault = fault_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout, reset mid-access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_read, ex_mem_write;
  logic [8:0]  ex_addr;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_func3;
  logic        stall;
  logic [31:0] rd_data;
  logic        access_fault;
  logic        mem_req, mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errors  = 0;

  int          stall_cnt, req_cnt, fault_cnt;
  logic [6:0]  cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata, done_rd, final_rd;
  logic        cap_we;

  load_store_unit #(.DATA_W(32), .DM_ADDRESS(9), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_func3(ex_func3),
    .stall(stall), .rd_data(rd_data), .access_fault(access_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic clear_ex();
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_addr      = '0;
    ex_wdata     = '0;
    ex_func3     = '0;
  endtask

  // Runs one instruction through the unit, holding ex_* while stalled, and
  // records what the memory side and pipeline saw. ack_at = -1 never acks.
  task automatic do_access(input logic r, input logic w, input logic [8:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input logic [31:0] rdat, input int ack_at);
    bit done = 0;
    stall_cnt = 0; req_cnt = 0; fault_cnt = 0;
    cap_addr = '0; cap_be = '0; cap_wdata = '0; cap_we = 1'b0;
    @(negedge clk);
    ex_mem_read = r; ex_mem_write = w; ex_addr = a; ex_wdata = wd; ex_func3 = f3;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        if (req_cnt == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdat;
        end
        req_cnt++;
        cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
      end
      if (access_fault) fault_cnt++;
      if (stall) stall_cnt++;
      else begin
        done    = 1;
        done_rd = rd_data;
      end
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL access_budget: stall never released within 40 cycles");
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      clear_ex();
      mem_ack = 1'b0;
      #1;
      if (access_fault) fault_cnt++;
      if (mem_req) req_cnt++;
    end
    final_rd = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_ex();
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({stall, mem_req, mem_we, access_fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {stall, mem_req, mem_we, access_fault});
    end
    vectors++;
    if ({mem_addr, mem_be, mem_wdata, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h be %b wdata %h rd %h want all zero",
               mem_addr, mem_be, mem_wdata, rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word_load();
    do_access(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    vectors++;
    if (stall_cnt !== 2) begin errors++; $display("FAIL lw_stall: got %0d want 2", stall_cnt); end
    vectors++;
    if (req_cnt !== 1) begin errors++; $display("FAIL lw_req_cycles: got %0d want 1", req_cnt); end
    vectors++;
    if (cap_addr !== 7'h04 || cap_be !== 4'b1111 || cap_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_memside: addr %h be %b we %b want 04 1111 0", cap_addr, cap_be, cap_we);
    end
    vectors++;
    if (done_rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_rd: got %h want deadbeef", done_rd);
    end
  endtask

  task automatic test_subword_loads();
    logic [8:0]  addrs [4] = '{9'h003, 9'h003, 9'h000, 9'h002};
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [3:0]  bes   [4] = '{4'b1000, 4'b1000, 4'b0011, 4'b1100};
    logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 1'b0, addrs[i], 32'h0, f3s[i], 32'h80FF7F01, 0);
      vectors++;
      if (done_rd !== exps[i] || cap_be !== bes[i]) begin
        errors++;
        $display("FAIL subload_%0d: rd %h be %b want %h %b", i, done_rd, cap_be, exps[i], bes[i]);
      end
    end
  endtask

  task automatic test_subword_stores();
    do_access(1'b0, 1'b1, 9'h005, 32'h123456AB, 3'b000, 32'hFFFFFFFF, 0);
    vectors++;
    if (cap_be !== 4'b0010 || cap_wdata !== 32'hABABABAB || cap_we !== 1'b1 || cap_addr !== 7'h01) begin
      errors++;
      $display("FAIL sb: be %b wdata %h we %b addr %h want 0010 abababab 1 01",
               cap_be, cap_wdata, cap_we, cap_addr);
    end
    vectors++;
    if (final_rd !== 32'h000080FF) begin
      errors++; $display("FAIL sb_rd_hold: got %h want 000080ff", final_rd);
    end
    do_access(1'b0, 1'b1, 9'h006, 32'h123456AB, 3'b001, 32'hFFFFFFFF, 0);
    vectors++;
    if (cap_be !== 4'b1100 || cap_wdata !== 32'h56AB56AB || cap_we !== 1'b1) begin
      errors++;
      $display("FAIL sh: be %b wdata %h we %b want 1100 56ab56ab 1", cap_be, cap_wdata, cap_we);
    end
  endtask

  task automatic test_faults();
    do_access(1'b1, 1'b0, 9'h002, 32'h0, 3'b010, 32'h11111111, 0);
    vectors++;
    if (stall_cnt !== 0 || req_cnt !== 0 || fault_cnt !== 1 || final_rd !== 32'h0) begin
      errors++;
      $display("FAIL lw_misaligned: stall %0d req %0d fault %0d rd %h want 0 0 1 0",
               stall_cnt, req_cnt, fault_cnt, final_rd);
    end
    do_access(1'b1, 1'b0, 9'h000, 32'h0, 3'b011, 32'h0, 0);
    vectors++;
    if (stall_cnt !== 0 || req_cnt !== 0 || fault_cnt !== 1) begin
      errors++;
      $display("FAIL load_illegal_f3: stall %0d req %0d fault %0d want 0 0 1",
               stall_cnt, req_cnt, fault_cnt);
    end
    do_access(1'b1, 1'b0, 9'h004, 32'h0, 3'b010, 32'hCAFEF00D, 0);
    do_access(1'b1, 1'b1, 9'h010, 32'h0, 3'b010, 32'h22222222, 0);
    vectors++;
    if (stall_cnt !== 0 || req_cnt !== 0 || fault_cnt !== 1 || final_rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_wr_both: stall %0d req %0d fault %0d rd %h want 0 0 1 0",
               stall_cnt, req_cnt, fault_cnt, final_rd);
    end
  endtask

  task automatic test_wait_latency();
    do_access(1'b1, 1'b0, 9'h01C, 32'h0, 3'b010, 32'h13579BDF, 2);
    vectors++;
    if (stall_cnt !== 4 || req_cnt !== 3 || done_rd !== 32'h13579BDF || fault_cnt !== 0) begin
      errors++;
      $display("FAIL lw_ack_late: stall %0d req %0d rd %h fault %0d want 4 3 13579bdf 0",
               stall_cnt, req_cnt, done_rd, fault_cnt);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 9'h008, 32'h0, 3'b010, 32'h0, -1);
    vectors++;
    if (req_cnt !== 4) begin errors++; $display("FAIL timeout_req: got %0d want 4", req_cnt); end
    vectors++;
    if (stall_cnt !== 5 || fault_cnt !== 1 || done_rd !== 32'h0) begin
      errors++;
      $display("FAIL timeout_resp: stall %0d fault %0d rd %h want 5 1 0",
               stall_cnt, fault_cnt, done_rd);
    end
  endtask

  task automatic test_reset_mid_access();
    do_access(1'b1, 1'b0, 9'h00C, 32'h0, 3'b100, 32'h000000A5, 0);
    @(negedge clk);
    ex_mem_read = 1'b1; ex_addr = 9'h020; ex_func3 = 3'b010; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_wait1_req: got %b want 1", mem_req); end
    @(negedge clk);
    reset = 1'b1;
    clear_ex();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_req, stall, access_fault} !== 3'b000 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: req/stall/fault %b rd %h want 000 0",
               {mem_req, stall, access_fault}, rd_data);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({mem_req, access_fault} !== 2'b00 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL stray_ack: req/fault %b rd %h want 00 0", {mem_req, access_fault}, rd_data);
    end
    do_access(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h0BADF00D, 0);
    vectors++;
    if (done_rd !== 32'h0BADF00D || req_cnt !== 1 || cap_addr !== 7'h08) begin
      errors++;
      $display("FAIL post_reset_lw: rd %h req %0d addr %h want 0badf00d 1 08",
               done_rd, req_cnt, cap_addr);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_subword_stores();
    test_faults();
    test_wait_latency();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
